// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel tick, syncs, video_on,
// raster position and line/frame strobes, with a freeze enable.
// Ports: clk, reset (async, active-high), en (1 = run, 0 = freeze)
//   p_tick      pixel strobe, 1 clk wide, once per CLK_DIV clks
//   hsync/vsync sync pulses, active level SYNC_POL
//   video_on    1 inside the visible area
//   pixel_x/y   current column/row
//   line_start  1 for the first clk of each line
//   frame_start 1 for the first clk of each frame
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] X_MAX  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_MAX  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_VIS  = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] Y_VIS  = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_DISPLAY + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_DISPLAY + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_DISPLAY + V_FP + V_SYNC - 1);

  localparam logic ACT = (SYNC_POL != 0);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             vo_nxt;
  logic             ls_q;
  logic             fs_q;

  assign p_tick = en & (div == DIV_MAX);

  // Next raster position; decodes use it so they line up with the counters.
  always_comb begin
    x_nxt = pixel_x;
    y_nxt = pixel_y;
    if (p_tick) begin
      if (pixel_x == X_MAX) begin
        x_nxt = '0;
        y_nxt = (pixel_y == Y_MAX) ? '0 : pixel_y + 1'b1;
      end else begin
        x_nxt = pixel_x + 1'b1;
      end
    end
    hs_nxt = (x_nxt >= HS_BEG && x_nxt <= HS_END) ? ACT : ~ACT;
    vs_nxt = (y_nxt >= VS_BEG && y_nxt <= VS_END) ? ACT : ~ACT;
    vo_nxt = (x_nxt < X_VIS) && (y_nxt < Y_VIS);
  end

  // Reset parks the raster on the last pixel so the first tick enters (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      pixel_x  <= X_MAX;
      pixel_y  <= Y_MAX;
      hsync    <= ~ACT;
      vsync    <= ~ACT;
      video_on <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      if (en) begin
        div <= (div == DIV_MAX) ? '0 : div + 1'b1;
      end
      pixel_x  <= x_nxt;
      pixel_y  <= y_nxt;
      hsync    <= hs_nxt;
      vsync    <= vs_nxt;
      video_on <= vo_nxt;
      ls_q     <= p_tick && (x_nxt == '0);
      fs_q     <= p_tick && (x_nxt == '0) && (y_nxt == '0);
    end
  end

  // Strobes are suppressed while frozen.
  assign line_start  = ls_q & en;
  assign frame_start = fs_q & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (default timing,
// short vertical timing, tiny 14x7 raster) checked against hand-timed vectors.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  int   cyc = 0;

  logic       a_pt, a_hs, a_vs, a_vo, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_pt, b_hs, b_vs, b_vo, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_pt, c_hs, c_vs, c_vo, c_ls, c_fs;
  logic [3:0] c_x, c_y;

  vga_timing_gen u_a (
    .clk(clk), .reset(reset), .en(en),
    .p_tick(a_pt), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
    .pixel_x(a_x), .pixel_y(a_y),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_b (
    .clk(clk), .reset(reset), .en(en),
    .p_tick(b_pt), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
    .pixel_x(b_x), .pixel_y(b_y),
    .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1),
    .H_DISPLAY(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .CNT_W(4)
  ) u_c (
    .clk(clk), .reset(reset), .en(en),
    .p_tick(c_pt), .hsync(c_hs), .vsync(c_vs), .video_on(c_vo),
    .pixel_x(c_x), .pixel_y(c_y),
    .line_start(c_ls), .frame_start(c_fs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation vector: {x[9:0], y[9:0], hs, vs, vo, pt, ls, fs}
  logic [25:0] obs [3];
  assign obs[0] = {a_x, a_y, a_hs, a_vs, a_vo, a_pt, a_ls, a_fs};
  assign obs[1] = {b_x, b_y, b_hs, b_vs, b_vo, b_pt, b_ls, b_fs};
  assign obs[2] = {6'd0, c_x, 6'd0, c_y,
                   c_hs, c_vs, c_vo, c_pt, c_ls, c_fs};

  typedef struct {
    int          when;
    int          dut;
    string       name;
    logic [25:0] exp;
    logic [25:0] msk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [25:0] ALL  = '1;
  localparam logic [25:0] NOPT = ~26'd4;

  function automatic logic [25:0] pk(int x, int y, bit hs, bit vs,
                                     bit vo, bit pt, bit ls, bit fs);
    return {10'(x), 10'(y), hs, vs, vo, pt, ls, fs};
  endfunction

  // Keep the queue ordered by sample cycle.
  task automatic push(int when, int dut, string name,
                      logic [25:0] exp, logic [25:0] msk);
    exp_t e;
    int   i;
    e.when = when;
    e.dut  = dut;
    e.name = name;
    e.exp  = exp;
    e.msk  = msk;
    i = q.size();
    while (i > 0 && q[i-1].when > when) i--;
    q.insert(i, e);
  endtask

  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: samples on the falling edge, pops every entry due this cycle.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].when <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.when != cyc || ((obs[e.dut] ^ e.exp) & e.msk) != 0) begin
          errors++;
          $display("FAIL %s dut%0d cyc %0d: got x=%0d y=%0d f=%b, want x=%0d y=%0d f=%b",
                   e.name, e.dut, cyc,
                   obs[e.dut][25:16], obs[e.dut][15:6], obs[e.dut][5:0],
                   e.exp[25:16], e.exp[15:6], e.exp[5:0]);
        end
      end
    end
  end

  initial begin : stim
    int x;
    int y;

    // Reset state and start-up (release after posedge 5).
    push(3, 0, "a_rst", pk(799, 524, 1, 1, 0, 0, 0, 0), ALL);
    push(3, 1, "b_rst", pk(799, 6, 1, 1, 0, 0, 0, 0), ALL);
    push(3, 2, "c_rst", pk(13, 6, 0, 0, 0, 0, 0, 0), NOPT);
    push(7, 0, "a_div2", pk(799, 524, 1, 1, 0, 0, 0, 0), ALL);
    push(8, 0, "a_tick1", pk(799, 524, 1, 1, 0, 1, 0, 0), ALL);
    push(9, 0, "a_origin", pk(0, 0, 1, 1, 1, 0, 1, 1), ALL);
    push(9, 1, "b_origin", pk(0, 0, 1, 1, 1, 0, 1, 1), ALL);
    push(10, 0, "a_strb_clr", pk(0, 0, 1, 1, 1, 0, 0, 0), ALL);
    push(5, 2, "c_tick1", pk(13, 6, 0, 0, 0, 1, 0, 0), ALL);

    // Tiny raster: every clk is a pixel; whole frame plus next origin.
    for (int n = 0; n <= 98; n++) begin
      x = n % 14;
      y = (n / 14) % 7;
      push(6 + n, 2, "c_frame",
           pk(x, y, x >= 10 && x <= 11, y == 5, x < 8 && y < 4,
              1, x == 0, x == 0 && y == 0), ALL);
    end

    goto(5);
    reset = 1'b0;

    // Horizontal timing on the default raster (pixel n at cyc 9+4n).
    push(2565, 0, "a_x639", pk(639, 0, 1, 1, 1, 0, 0, 0), ALL);
    push(2569, 0, "a_x640", pk(640, 0, 1, 1, 0, 0, 0, 0), ALL);
    push(2629, 0, "a_x655", pk(655, 0, 1, 1, 0, 0, 0, 0), ALL);
    push(2633, 0, "a_hs_on", pk(656, 0, 0, 1, 0, 0, 0, 0), ALL);
    push(2636, 0, "a_hs_tick", pk(656, 0, 0, 1, 0, 1, 0, 0), ALL);
    push(3016, 0, "a_hs_last", pk(751, 0, 0, 1, 0, 1, 0, 0), ALL);
    push(3017, 0, "a_hs_off", pk(752, 0, 1, 1, 0, 0, 0, 0), ALL);
    push(3205, 0, "a_x799", pk(799, 0, 1, 1, 0, 0, 0, 0), ALL);
    push(3209, 0, "a_line1", pk(0, 1, 1, 1, 1, 0, 1, 0), ALL);
    push(3209, 1, "b_line1", pk(0, 1, 1, 1, 1, 0, 1, 0), ALL);
    push(3210, 0, "a_ls_clr", pk(0, 1, 1, 1, 1, 0, 0, 0), ALL);
    push(6409, 0, "a_line2", pk(0, 2, 1, 1, 1, 0, 1, 0), ALL);

    // Vertical timing on the short raster (vsync at y=5, 7 lines).
    push(12809, 1, "b_y4", pk(0, 4, 1, 1, 0, 0, 1, 0), ALL);
    push(16009, 1, "b_vs_on", pk(0, 5, 1, 0, 0, 0, 1, 0), ALL);
    push(19208, 1, "b_vs_last", pk(799, 5, 1, 0, 0, 1, 0, 0), ALL);
    push(19209, 1, "b_vs_off", pk(0, 6, 1, 1, 0, 0, 1, 0), ALL);
    push(22409, 1, "b_frame2", pk(0, 0, 1, 1, 1, 0, 1, 1), ALL);
    push(22409, 0, "a_line7", pk(0, 7, 1, 1, 1, 0, 1, 0), ALL);

    // Freeze at pixel_x=100 (entered at 22809, div=1 when en drops).
    push(22810, 0, "a_frz0", pk(100, 7, 1, 1, 1, 0, 0, 0), ALL);
    push(22811, 0, "a_frz1", pk(100, 7, 1, 1, 1, 0, 0, 0), ALL);
    push(22835, 0, "a_frz2", pk(100, 7, 1, 1, 1, 0, 0, 0), ALL);
    push(22835, 1, "b_frz", pk(100, 0, 1, 1, 1, 0, 0, 0), ALL);
    push(22859, 0, "a_frz3", pk(100, 7, 1, 1, 1, 0, 0, 0), ALL);
    push(22860, 0, "a_resume", pk(100, 7, 1, 1, 1, 0, 0, 0), ALL);
    push(22862, 0, "a_res_tick", pk(100, 7, 1, 1, 1, 1, 0, 0), ALL);
    push(22863, 0, "a_x101", pk(101, 7, 1, 1, 1, 0, 0, 0), ALL);
    push(22899, 0, "a_x110", pk(110, 7, 1, 1, 1, 0, 0, 0), ALL);

    goto(22810);
    en = 1'b0;
    goto(22860);
    en = 1'b1;

    // Mid-frame reset pulse, then restart.
    push(22900, 0, "a_rst2", pk(799, 524, 1, 1, 0, 0, 0, 0), ALL);
    push(22900, 1, "b_rst2", pk(799, 6, 1, 1, 0, 0, 0, 0), ALL);
    push(22900, 2, "c_rst2", pk(13, 6, 0, 0, 0, 0, 0, 0), NOPT);
    push(22903, 0, "a_rst2_hold", pk(799, 524, 1, 1, 0, 0, 0, 0), ALL);
    push(22905, 2, "c_rel2", pk(13, 6, 0, 0, 0, 1, 0, 0), ALL);
    push(22906, 2, "c_origin2", pk(0, 0, 0, 0, 1, 1, 1, 1), ALL);
    push(22908, 0, "a_tick2", pk(799, 524, 1, 1, 0, 1, 0, 0), ALL);
    push(22909, 0, "a_origin2", pk(0, 0, 1, 1, 1, 0, 1, 1), ALL);

    goto(22900);
    reset = 1'b1;
    goto(22905);
    reset = 1'b0;
    goto(22915);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations never sampled, want 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
